// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states,
// requester IDs and the byte-count helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter. On a tie the port not granted last wins; the
// pointer moves on every accepted grant, so `last` names the current owner.
module dmem_rr_arb
  import dmem_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       last
);

  // ptr_q is the port favoured on the next tie; the core is favoured out of reset.
  logic ptr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= PORT_CORE;
    end else if (advance && (gnt != 2'b00)) begin
      ptr_q <= gnt[0] ? PORT_DBG : PORT_CORE;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr_q == PORT_DBG) ? 2'b10 : 2'b01;
    end
  end

  assign last = ~ptr_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: arbitrates the core MEM stage and the debug port onto
// one data_mem instance, rejects bad accesses and sequences its 2-cycle read.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [1:0]        c_size,
  input  logic              c_sext,
  output logic              c_done,
  output logic              c_err,
  output logic [31:0]       c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_sext,
  output logic              d_done,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [1:0]        mem_byte_size,
  output logic              mem_sign_ext,
  input  logic [31:0]       mem_read_data
);

  localparam int MA_W = $clog2(MEM_BYTES);

  state_t            state_q, state_d;
  logic [1:0]        gnt;
  logic              last;
  logic              granted;
  logic              s_we, s_sext, s_err;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [1:0]        s_size;
  logic [ADDR_W:0]   s_end;
  logic [1:0]        done_vec, err_vec;
  logic              rd_ret;

  // Grants are only taken in IDLE, so `last` doubles as the latched read owner.
  dmem_rr_arb u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({d_req, c_req}),
    .advance (state_q == IDLE),
    .gnt     (gnt),
    .last    (last)
  );

  assign granted = (gnt != 2'b00);
  assign s_we    = gnt[1] ? d_we    : c_we;
  assign s_addr  = gnt[1] ? d_addr  : c_addr;
  assign s_wdata = gnt[1] ? d_wdata : c_wdata;
  assign s_size  = gnt[1] ? d_size  : c_size;
  assign s_sext  = gnt[1] ? d_sext  : c_sext;

  // End address is one bit wider so a near-2^ADDR_W address cannot wrap past the check.
  assign s_end = {1'b0, s_addr} + (ADDR_W+1)'(size_bytes(s_size));
  assign s_err = (s_size == SZ_BAD)
              || ((s_size == SZ_HALF) && s_addr[0])
              || ((s_size == SZ_WORD) && (s_addr[1:0] != 2'b00))
              || (s_end > (ADDR_W+1)'(MEM_BYTES));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (granted && !s_we && !s_err) state_d = RD_WAIT;
      RD_WAIT: state_d = RD_DONE;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even if requests are asserted.
  always_comb begin
    done_vec       = 2'b00;
    err_vec        = 2'b00;
    rd_ret         = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    mem_byte_size  = '0;
    mem_sign_ext   = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (granted && s_err) begin
            done_vec = gnt;
            err_vec  = gnt;
          end else if (granted) begin
            mem_address   = 32'(s_addr[MA_W-1:0]);
            mem_byte_size = s_size;
            if (s_we) begin
              mem_memwrite   = 1'b1;
              mem_write_data = s_wdata;
              done_vec       = gnt;
            end else begin
              mem_memread  = 1'b1;
              mem_sign_ext = s_sext;
            end
          end
        end
        RD_DONE: begin
          done_vec = (last == PORT_DBG) ? 2'b10 : 2'b01;
          rd_ret   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign c_done  = done_vec[0];
  assign c_err   = err_vec[0];
  assign c_rdata = (done_vec[0] && rd_ret) ? mem_read_data : 32'h0;
  assign c_stall = reset_n & c_req & ~c_done;
  assign d_done  = done_vec[1];
  assign d_err   = err_vec[1];
  assign d_rdata = (done_vec[1] && rd_ret) ? mem_read_data : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a behavioural byte-array model predicts every
// completion, and a stand-in data_mem with a 2-cycle registered read sits behind the DUT.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        c_req, c_we, c_sext, d_req, d_we, d_sext;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [1:0]  c_size, d_size;
  logic        c_done, c_err, c_stall, d_done, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_address, mem_write_data;
  logic        mem_memwrite, mem_memread, mem_sign_ext;
  logic [1:0]  mem_byte_size;
  logic [31:0] mem_read_data = 32'h0;
  logic [31:0] rd_pipe       = 32'h0;

  logic [7:0] dm      [1024] = '{default: 8'h00};
  logic [7:0] ref_mem [1024] = '{default: 8'h00};
  exp_t exp_c[$];
  exp_t exp_d[$];

  int total = 0, bad = 0, cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, stall_c = 0;

  dmem_ctrl #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_size(c_size), .c_sext(c_sext), .c_done(c_done), .c_err(c_err),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_sext(d_sext), .d_done(d_done), .d_err(d_err),
    .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_byte_size(mem_byte_size), .mem_sign_ext(mem_sign_ext),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Stand-in data_mem: little-endian, read data appears two edges after memread.
  function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    logic [31:0] w;
    w = {dm[10'(a[9:0] + 10'd3)], dm[10'(a[9:0] + 10'd2)], dm[10'(a[9:0] + 10'd1)], dm[a[9:0]]};
    case (sz)
      2'b00:   return sx ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
      2'b01:   return sx ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clock) begin
    if (mem_memwrite) begin
      dm[mem_address[9:0]] <= mem_write_data[7:0];
      if (mem_byte_size != 2'b00) dm[10'(mem_address[9:0] + 10'd1)] <= mem_write_data[15:8];
      if (mem_byte_size == 2'b10) begin
        dm[10'(mem_address[9:0] + 10'd2)] <= mem_write_data[23:16];
        dm[10'(mem_address[9:0] + 10'd3)] <= mem_write_data[31:24];
      end
    end
    rd_pipe       <= mem_memread ? dm_read(mem_address, mem_byte_size, mem_sign_ext) : 32'h0;
    mem_read_data <= rd_pipe;
  end

  // Reference model: size in bytes is 2^size; alignment, range and extension by plain arithmetic.
  function automatic exp_t model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input bit sext);
    exp_t   e;
    int     n;
    longint a, u;
    e = '0;
    n = 1 << size;
    a = longint'(addr);
    if (size == 2'b11 || (a % n) != 0 || a + n > 1024) begin
      e.err = 1'b1;
      return e;
    end
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
    end else begin
      u = 0;
      for (int i = 0; i < n; i++) u = u + (longint'(ref_mem[int'(a) + i]) << (8 * i));
      if (sext && u >= (longint'(1) << (8 * n - 1))) u = u - (longint'(1) << (8 * n));
      e.rdata = u[31:0];
    end
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issues one access at posedge+1, waits for its done, releases req at the next posedge+1.
  task automatic apply_stimulus(input bit port, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size, input bit sext,
                                output int lat, output int done_cyc);
    exp_t e;
    bit   seen;
    e = model(we, addr, wdata, size, sext);
    if (port) begin
      exp_d.push_back(e);
      d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_sext = sext; d_req = 1'b1;
    end else begin
      exp_c.push_back(e);
      c_we = we; c_addr = addr; c_wdata = wdata; c_size = size; c_sext = sext; c_req = 1'b1;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 50) begin
      @(negedge clock);
      lat++;
      seen = port ? d_done : c_done;
    end
    done_cyc = cyc;
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: port %0d got no done, required one within 50 cycles", port);
    end
    @(posedge clock);
    #1;
    if (port) d_req = 1'b0; else c_req = 1'b0;
  endtask

  task automatic rand_port(input bit port, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      int          lat, dc;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_0400;
      else a = (port ? 32'd512 : 32'd0) + 32'($urandom_range(0, 511));
      apply_stimulus(port, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), lat, dc);
      check_output("max_wait", 32'(lat <= 6), 32'd1);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks idle-bus/idle-rdata rules each cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_memread) rd_cnt++;
      if (mem_memwrite) wr_cnt++;
      if (c_stall) stall_c++;
      check_output("c_stall", 32'(c_stall), 32'(c_req & ~c_done));
      if (!mem_memread && !mem_memwrite)
        check_output("mem_idle_zero",
                     32'(|{mem_address, mem_write_data, mem_byte_size, mem_sign_ext}), 32'd0);
      if (c_done) begin
        if (exp_c.size() == 0) check_output("c_unexpected_done", 32'(c_done), 32'd0);
        else begin
          exp_t e;
          e = exp_c.pop_front();
          check_output("c_err", 32'(c_err), 32'(e.err));
          check_output("c_rdata", c_rdata, e.rdata);
        end
      end else check_output("c_rdata_idle", c_rdata, 32'h0);
      if (d_done) begin
        if (exp_d.size() == 0) check_output("d_unexpected_done", 32'(d_done), 32'd0);
        else begin
          exp_t e;
          e = exp_d.pop_front();
          check_output("d_err", 32'(d_err), 32'(e.err));
          check_output("d_rdata", d_rdata, e.rdata);
        end
      end else check_output("d_rdata_idle", d_rdata, 32'h0);
    end
  end

  function automatic logic [31:0] any_output();
    return 32'(|{c_done, c_err, c_rdata, c_stall, d_done, d_err, d_rdata, mem_address,
                 mem_write_data, mem_memwrite, mem_memread, mem_byte_size, mem_sign_ext});
  endfunction

  initial begin
    int lat, lat2, lat3, dc, prev_dc, r0, w0;
    logic [1:0]  err_sz [6] = '{SZ_HALF, SZ_WORD, SZ_BAD, SZ_WORD, SZ_BYTE, SZ_WORD};
    logic [31:0] err_ad [6] = '{32'h3, 32'h6, 32'h0, 32'h3FE, 32'h400, 32'hFFFF_FFFC};

    reset_n = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_size = 0; c_sext = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0; d_sext = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_output("reset_outputs", any_output(), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_output("idle_outputs", any_output(), 32'h0);
    @(posedge clock);
    #1;

    $display("[TB] simultaneous loads from reset");
    fork
      begin
        apply_stimulus(PORT_CORE, 1'b0, 32'h40, 32'h0, SZ_WORD, 1'b0, lat, dc);
        apply_stimulus(PORT_CORE, 1'b0, 32'h44, 32'h0, SZ_WORD, 1'b0, lat3, dc);
      end
      apply_stimulus(PORT_DBG, 1'b0, 32'h240, 32'h0, SZ_WORD, 1'b0, lat2, dc);
    join
    check_output("arb_core_first", 32'(lat), 32'd3);
    check_output("arb_dbg_second", 32'(lat2), 32'd6);
    check_output("arb_dbg_wins_tie", 32'(lat3), 32'd6);

    $display("[TB] store/load word");
    w0 = wr_cnt;
    apply_stimulus(PORT_CORE, 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, lat, dc);
    check_output("store_latency", 32'(lat), 32'd1);
    check_output("store_strobes", 32'(wr_cnt - w0), 32'd1);
    r0 = rd_cnt;
    stall_c = 0;
    apply_stimulus(PORT_CORE, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, lat, dc);
    check_output("load_latency", 32'(lat), 32'd3);
    check_output("load_strobes", 32'(rd_cnt - r0), 32'd1);
    check_output("load_stall_cycles", 32'(stall_c), 32'd2);

    $display("[TB] byte sign extension");
    apply_stimulus(PORT_CORE, 1'b1, 32'h21, 32'h0000_0080, SZ_BYTE, 1'b0, lat, dc);
    apply_stimulus(PORT_CORE, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b1, lat, dc);
    apply_stimulus(PORT_CORE, 1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b0, lat, dc);
    apply_stimulus(PORT_DBG, 1'b0, 32'h20, 32'h0, SZ_HALF, 1'b1, lat, dc);

    $display("[TB] rejected accesses");
    for (int i = 0; i < 6; i++) begin
      r0 = rd_cnt;
      w0 = wr_cnt;
      apply_stimulus(PORT_CORE, 1'(i % 2), err_ad[i], 32'h1234_5678, err_sz[i], 1'b0, lat, dc);
      check_output("err_latency", 32'(lat), 32'd1);
      check_output("err_no_strobe", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
    end
    apply_stimulus(PORT_CORE, 1'b1, 32'h3FC, 32'hCAFE_F00D, SZ_WORD, 1'b0, lat, dc);
    apply_stimulus(PORT_CORE, 1'b0, 32'h3FE, 32'h0, SZ_HALF, 1'b0, lat, dc);
    check_output("top_half_latency", 32'(lat), 32'd3);

    $display("[TB] reset during read");
    c_we = 1'b0; c_addr = 32'h10; c_size = SZ_WORD; c_sext = 1'b0; c_req = 1'b1;
    @(negedge clock);
    check_output("inflight_memread", 32'(mem_memread), 32'd1);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(negedge clock);
    check_output("reset_mid_read", any_output(), 32'h0);
    @(posedge clock);
    @(negedge clock);
    check_output("reset_mid_read_hold", any_output(), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    c_req   = 1'b0;
    apply_stimulus(PORT_CORE, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, lat, dc);
    check_output("post_reset_load_latency", 32'(lat), 32'd3);

    $display("[TB] debug burst writes");
    prev_dc = 0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(PORT_DBG, 1'b1, 32'h100 + 32'(4 * i), $urandom, SZ_WORD, 1'b0, lat, dc);
      check_output("burst_latency", 32'(lat), 32'd1);
      if (i > 0) check_output("burst_consecutive", 32'(dc - prev_dc), 32'd1);
      prev_dc = dc;
    end
    for (int i = 0; i < 8; i++)
      apply_stimulus(PORT_CORE, 1'b0, 32'h100 + 32'(4 * i), 32'h0, SZ_WORD, 1'b0, lat, dc);

    $display("[TB] random traffic on both ports");
    fork
      rand_port(PORT_CORE, 150);
      rand_port(PORT_DBG, 150);
    join

    repeat (4) @(posedge clock);
    check_output("scoreboard_drained", 32'(exp_c.size() + exp_d.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Two-requester controller in front of data_mem: the core MEM stage (port c_) and the debug/loader port (port d_).
- Arbitrates between the two ports.
- Checks alignment and range.
- Sequences data_mem's 2-cycle registered read.
- Returns a completion pulse per access and a stall to the core.
- Sits between MEM-stage logic and the data_mem instance; drives all data_mem inputs.

Parameters:
MEM_BYTES, 1024, data memory size in bytes; addresses >= MEM_BYTES are out of range.
ADDR_W, 32, request address width.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
c_req  in  1  core request; held stable until c_done
c_we  in  1  core: 1 = store, 0 = load
c_addr  in  32  core byte address
c_wdata  in  32  core store data
c_size  in  2  core size: 00 byte, 01 half, 10 word, 11 illegal
c_sext  in  1  core load sign-extend
c_done  out  1  core access complete, 1-cycle pulse
c_err  out  1  core access rejected (misaligned, illegal size, or range); valid with c_done
c_rdata  out  32  core load data, valid when c_done & ~c_we & ~c_err
c_stall  out  1  c_req & ~c_done
d_req, d_we, d_addr, d_wdata, d_size, d_sext  in  1/1/32/32/2/1  debug port, same rules as core port
d_done, d_err, d_rdata  out  1/1/32  debug port, same rules as core port
mem_address  out  32  to data_mem address
mem_write_data  out  32  to data_mem write_data
mem_memwrite  out  1  to data_mem memwrite
mem_memread  out  1  to data_mem memread
mem_byte_size  out  2  to data_mem byte_size
mem_sign_ext  out  1  to data_mem sign_ext
mem_read_data  in  32  from data_mem read_data

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, RR pointer=core.
  - All outputs 0; any in-flight read is discarded, with no done pulse.
- States: IDLE, RD_WAIT, RD_DONE.
- IDLE:
  - Select a requester by round-robin: on a tie, grant the port not granted last; the pointer updates on every grant.
  - Error check first. err if any of:
    - size=11
    - half with addr[0]=1
    - word with addr[1:0]!=0
    - addr+bytes > MEM_BYTES
  - On err: no memory strobe; done=1 and err=1 in the same cycle; stay IDLE.
  - Store: mem_memwrite=1 with that port's addr/wdata/size for one cycle; done=1 the same cycle; stay IDLE.
  - Load: mem_memread=1 for one cycle (cycle T) with addr/size/sext; latch the owner ID and sext; go to RD_WAIT.
- RD_WAIT (T+1):
  - mem_memread=0, mem_memwrite=0; no new grant.
  - Go to RD_DONE.
- RD_DONE (T+2):
  - Owner's done=1; owner's rdata=mem_read_data.
  - Go to IDLE; no new grant this cycle.
  - Load latency is 3 cycles from grant to done.
- Unselected port: done=0; stall continues.
- rdata is 32'h0 whenever the port's done=0 or the access is a store/err.
- mem_* outputs are 0 whenever no strobe is active.
- A requester must not change its request fields while req=1 and done=0. A dropped request is ignored until it reasserts.
- The loser of a simultaneous request is served at the next IDLE grant. It waits at most one full access, so neither port starves.
- Back-to-back stores from one port complete 1 per cycle, alternating with the other port if both request.
- Address is truncated to data_mem's 10 bits only after the range check passes.

Decomposition:
- dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BAD
  - state enum {IDLE, RD_WAIT, RD_DONE}
  - port IDs PORT_CORE=0, PORT_DBG=1
  - function size_bytes(size)
- Sub-module dmem_rr_arb: 2-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: one-hot gnt, last pointer.
  - Async active-low reset.

Test Plan:
- Core store word 0xDEADBEEF @0x10, then load word @0x10 → store c_done in grant cycle. Load: mem_memread for 1 cycle, c_done exactly 2 cycles later, c_rdata=0xDEADBEEF, c_stall high for 2 cycles.
- Store byte 0x80 @0x21; load byte sext=1 and sext=0 @0x21 → rdata 0xFFFFFF80 and 0x00000080.
- Half @0x3, word @0x6, size=11, word @0x3FE → c_done=c_err=1 same cycle; mem_memread=mem_memwrite=0 throughout.
- c_req and d_req loads asserted together from reset → core granted first, d granted at the following IDLE. Next simultaneous pair → d has lost last, so d wins.
- Core load in flight, reset_n low at T+1, release 2 cycles later → no c_done, all outputs 0, state IDLE, next core access is granted normally.
- Debug writes 8 consecutive words while core idle → 8 d_done pulses on 8 consecutive cycles; readback via core matches.
